vga_frame_scanner: RTL and testbench

Downstream consumer of the 320x240x24 dual-clock frame buffer. It runs entirely in the pixel-clock domain and generates 640x480@60 Hz VGA timing. It produces the frame buffer read address with 2x pixel and line replication, and drives aligned RGB, sync and blank signals to the ADV7123 DAC.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_timing_gen.sv | 86 ++++++++
 rtl/vga_frame_scanner.sv | 125 ++++++++++++
 tb/tb_vga_frame_scanner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared constants and types for the 640x480@60 VGA scanner
//                that reads a 320x240x24 frame buffer with 2x replication.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // 640x480@60 horizontal timing (pixel clocks)
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int H_TOTAL       = 800;

  // 640x480@60 vertical timing (lines)
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int V_TOTAL       = 525;

  // Frame buffer geometry
  localparam int VGA_SRC_WIDTH  = 320;
  localparam int VGA_SRC_HEIGHT = 240;

  localparam int ADDR_W = 17;
  localparam int CNT_W  = 10;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-pixel control flags carried down the alignment pipeline
  typedef struct packed {
    logic visible;
    logic hsync_n;
    logic vsync_n;
    logic frame_start;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{visible: 1'b0, hsync_n: 1'b1,
                                    vsync_n: 1'b1, frame_start: 1'b0};

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Horizontal/vertical scan counters and the combinational
//                visible/sync/frame-start flags for the current position.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  output cnt_t   h,
  output cnt_t   v,
  output flags_t flags,
  output logic   h_wrap,
  output logic   v_wrap
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST     = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VIS_C    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_C    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START_C = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END_C   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START_C = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END_C   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  // Next-position logic: disable parks the scan at (0,0); both wraps share one edge
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h      = h_q;
  assign v      = v_q;
  assign h_wrap = enable && (h_q == H_LAST);
  assign v_wrap = h_wrap && (v_q == V_LAST);

  // Flags describing the pixel the counters currently hold
  always_comb begin
    flags             = FLAGS_IDLE;
    flags.visible     = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    flags.hsync_n     = !((h_q >= HS_START_C) && (h_q < HS_END_C));
    flags.vsync_n     = !((v_q >= VS_START_C) && (v_q < VS_END_C));
    flags.frame_start = (h_q == '0) && (v_q == '0);
  end

endmodule
`default_nettype wire

// File: rtl/vga_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_scanner
//  Description : VGA scan-out of a 320x240 frame buffer at 640x480@60 with
//                2x pixel/line replication; drives an ADV7123 DAC with RGB,
//                sync and blank aligned two clocks after the scan counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int SRC_WIDTH = VGA_SRC_WIDTH
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset_n,
  input  logic        piul1Enable,
  output logic [16:0] poul17ReadAddress,
  input  logic [23:0] piul24ReadData,
  output logic [7:0]  poul8Red,
  output logic [7:0]  poul8Green,
  output logic [7:0]  poul8Blue,
  output logic        poul1HSync,
  output logic        poul1VSync,
  output logic        poul1Blank_n,
  output logic        poul1Sync_n,
  output logic        poul1FrameStart
);

  localparam cnt_t V_VIS_C = cnt_t'(V_VISIBLE);

  cnt_t   h;
  cnt_t   v;
  flags_t flags0;
  logic   h_wrap;
  logic   v_wrap;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk    (piul1Clock),
    .rst_n  (piul1Reset_n),
    .enable (piul1Enable),
    .h      (h),
    .v      (v),
    .flags  (flags0),
    .h_wrap (h_wrap),
    .v_wrap (v_wrap)
  );

  addr_t  base_q, base_d;
  addr_t  addr_q, addr_d;
  flags_t s1_q, s1_d;
  flags_t s2_q, s2_d;

  // Incremental (v>>1)*SRC_WIDTH + (h>>1); address freezes outside the visible area
  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (!piul1Enable) begin
      base_d = '0;
      addr_d = '0;
      s1_d   = FLAGS_IDLE;
      s2_d   = FLAGS_IDLE;
    end else begin
      s1_d = flags0;
      s2_d = s1_q;
      if (v_wrap) begin
        base_d = '0;
      end else if (h_wrap && v[0] && (v < V_VIS_C)) begin
        base_d = base_q + addr_t'(SRC_WIDTH);
      end
      if (flags0.visible) begin
        addr_d = base_q + addr_t'(h >> 1);
      end
    end
  end

  // Line base, read address and the two flag stages
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      base_q <= '0;
      addr_q <= '0;
      s1_q   <= FLAGS_IDLE;
      s2_q   <= FLAGS_IDLE;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  // RAM data arrives in the same cycle as stage-2 flags; mask it outside the active area
  rgb_t pixel;
  assign pixel = s2_q.visible ? rgb_t'(piul24ReadData) : '0;

  assign poul17ReadAddress = addr_q;
  assign poul8Red          = pixel.r;
  assign poul8Green        = pixel.g;
  assign poul8Blue         = pixel.b;
  assign poul1HSync        = s2_q.hsync_n;
  assign poul1VSync        = s2_q.vsync_n;
  assign poul1Blank_n      = s2_q.visible;
  assign poul1Sync_n       = 1'b1;
  assign poul1FrameStart   = s2_q.frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_frame_scanner
//  Description : Directed self-checking bench for vga_frame_scanner using a
//                reduced raster (32x12 visible, 48x19 total) so whole frames
//                fit in a short run. The RAM model returns data = address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_scanner;

  localparam int HV = 32, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int SRC = 16;
  localparam int HT = HV + HF + HS + HB;   // 48
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 912

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [16:0] addr;
  logic [23:0] rdata = '0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank_n, sync_n, fs;
  logic [23:0] rgb;

  int total = 0;
  int bad   = 0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  // Registered RAM model: one cycle latency, data equals address
  always @(posedge clk) rdata <= {7'd0, addr};

  vga_frame_scanner #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SRC_WIDTH (SRC)
  ) dut (
    .piul1Clock        (clk),
    .piul1Reset_n      (rst_n),
    .piul1Enable       (enable),
    .poul17ReadAddress (addr),
    .piul24ReadData    (rdata),
    .poul8Red          (red),
    .poul8Green        (green),
    .poul8Blue         (blue),
    .poul1HSync        (hsync),
    .poul1VSync        (vsync),
    .poul1Blank_n      (blank_n),
    .poul1Sync_n       (sync_n),
    .poul1FrameStart   (fs)
  );

  // Release reset with enable high; FrameStart must appear on the second edge
  task automatic test_start(input string tag);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (fs !== 1'b0) begin
      bad++;
      $display("FAIL %s_fs_early: got %b expected 0", tag, fs);
    end
    @(negedge clk);
    total++;
    if (fs !== 1'b1 || blank_n !== 1'b1 || rgb !== 24'd0) begin
      bad++;
      $display("FAIL %s_fs_at_2: got fs=%b blank_n=%b rgb=%0d expected fs=1 blank_n=1 rgb=0",
               tag, fs, blank_n, rgb);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (blank_n !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || sync_n !== 1'b1 ||
        fs !== 1'b0 || rgb !== 24'd0 || addr !== 17'd0) begin
      bad++;
      $display("FAIL reset_values: got blank_n=%b hs=%b vs=%b sync_n=%b fs=%b rgb=%0d addr=%0d expected 0,1,1,1,0,0,0",
               blank_n, hsync, vsync, sync_n, fs, rgb, addr);
    end
    test_start("reset");
  endtask

  // Called while the output is at pixel (0,0); walks one frame and lands on the next (0,0)
  task automatic test_frame_scan(input string tag);
    int e_blank = 0, e_hs = 0, e_vs = 0, e_rgb = 0, e_fs = 0;
    int f_blank = -1, f_hs = -1, f_vs = -1, f_rgb = -1, f_fs = -1;
    int blank_l3 = 0, hs_first = -1, hs_len = 0, vs_first = -1, vs_len = 0;
    int a2 = -1, a31 = -1, a51 = -1, a96 = -1, alast = -1;
    logic exp_vis, exp_hs, exp_vs, exp_fs;
    logic [23:0] exp_rgb;
    for (int c = 0; c < FRAME; c++) begin
      int x, y;
      x = c % HT;
      y = c / HT;
      exp_vis = (x < HV) && (y < VV);
      exp_hs  = !((x >= HV + HF) && (x < HV + HF + HS));
      exp_vs  = !((y >= VV + VF) && (y < VV + VF + VS));
      exp_fs  = (c == 0);
      exp_rgb = exp_vis ? 24'((y / 2) * SRC + (x / 2)) : 24'd0;
      if (blank_n !== exp_vis) begin e_blank++; if (f_blank < 0) f_blank = c; end
      if (hsync !== exp_hs)    begin e_hs++;    if (f_hs < 0)    f_hs = c;    end
      if (vsync !== exp_vs)    begin e_vs++;    if (f_vs < 0)    f_vs = c;    end
      if (fs !== exp_fs)       begin e_fs++;    if (f_fs < 0)    f_fs = c;    end
      if (rgb !== exp_rgb)     begin e_rgb++;   if (f_rgb < 0)   f_rgb = c;   end
      if (y == 3 && blank_n === 1'b1) blank_l3++;
      if (y == 0 && hsync === 1'b0) begin if (hs_first < 0) hs_first = c; hs_len++; end
      if (vsync === 1'b0) begin if (vs_first < 0) vs_first = c; vs_len++; end
      if (c == 2)                a2    = int'(rgb);
      if (c == 31)               a31   = int'(rgb);
      if (c == HT + 3)           a51   = int'(rgb);
      if (c == 2 * HT)           a96   = int'(rgb);
      if (c == 11 * HT + 31)     alast = int'(rgb);
      @(negedge clk);
    end
    total++; if (e_blank != 0) begin bad++; $display("FAIL %s_blank: got %0d errors (first at %0d) expected 0", tag, e_blank, f_blank); end
    total++; if (e_hs != 0)    begin bad++; $display("FAIL %s_hsync: got %0d errors (first at %0d) expected 0", tag, e_hs, f_hs); end
    total++; if (e_vs != 0)    begin bad++; $display("FAIL %s_vsync: got %0d errors (first at %0d) expected 0", tag, e_vs, f_vs); end
    total++; if (e_fs != 0)    begin bad++; $display("FAIL %s_framestart: got %0d errors (first at %0d) expected 0", tag, e_fs, f_fs); end
    total++; if (e_rgb != 0)   begin bad++; $display("FAIL %s_rgb: got %0d errors (first at %0d) expected 0", tag, e_rgb, f_rgb); end
    total++; if (blank_l3 != 32) begin bad++; $display("FAIL %s_blank_width: got %0d expected 32", tag, blank_l3); end
    total++; if (hs_first != 36 || hs_len != 6) begin bad++; $display("FAIL %s_hsync_pos: got start=%0d len=%0d expected start=36 len=6", tag, hs_first, hs_len); end
    total++; if (vs_first != 672 || vs_len != 96) begin bad++; $display("FAIL %s_vsync_pos: got start=%0d len=%0d expected start=672 len=96", tag, vs_first, vs_len); end
    total++; if (a2 != 1 || a31 != 15) begin bad++; $display("FAIL %s_addr_line0: got %0d,%0d expected 1,15", tag, a2, a31); end
    total++; if (a51 != 1) begin bad++; $display("FAIL %s_addr_line1: got %0d expected 1", tag, a51); end
    total++; if (a96 != 16) begin bad++; $display("FAIL %s_addr_line2: got %0d expected 16", tag, a96); end
    total++; if (alast != 95) begin bad++; $display("FAIL %s_addr_last: got %0d expected 95", tag, alast); end
    total++;
    if (fs !== 1'b1 || rgb !== 24'd0) begin
      bad++;
      $display("FAIL %s_frame_period: got fs=%b rgb=%0d expected fs=1 rgb=0", tag, fs, rgb);
    end
  endtask

  // Output sits at pixel (0,0) of a frame; drop enable while counters hold (10,5)
  task automatic test_mid_frame_disable();
    repeat (5 * HT + 10 - 2) @(negedge clk);
    total++;
    if (blank_n !== 1'b1) begin
      bad++;
      $display("FAIL disable_pre_visible: got blank_n=%b expected 1", blank_n);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (blank_n !== 1'b0 || rgb !== 24'd0 || hsync !== 1'b1 || vsync !== 1'b1 || fs !== 1'b0) begin
      bad++;
      $display("FAIL disable_idle: got blank_n=%b rgb=%0d hs=%b vs=%b fs=%b expected 0,0,1,1,0",
               blank_n, rgb, hsync, vsync, fs);
    end
    repeat (3) @(negedge clk);
    test_start("reenable");
    repeat (2) @(negedge clk);
    total++;
    if (rgb !== 24'd1) begin
      bad++;
      $display("FAIL reenable_addr: got rgb=%0d expected 1", rgb);
    end
  endtask

  // Output sits at pixel 2 of a frame; hit reset between edges at pixel (10,3)
  task automatic test_async_reset();
    repeat (3 * HT + 10 - 2) @(negedge clk);
    total++;
    if (rgb !== 24'd21 || blank_n !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got rgb=%0d blank_n=%b expected 21,1", rgb, blank_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (blank_n !== 1'b0 || rgb !== 24'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
        fs !== 1'b0 || addr !== 17'd0) begin
      bad++;
      $display("FAIL areset_immediate: got blank_n=%b rgb=%0d hs=%b vs=%b fs=%b addr=%0d expected 0,0,1,1,0,0",
               blank_n, rgb, hsync, vsync, fs, addr);
    end
    repeat (5) @(negedge clk);
    test_start("areset");
    test_frame_scan("areset_scan");
  endtask

  initial begin
    test_reset();
    test_frame_scan("scan");
    test_mid_frame_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
